// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, event format,
// event-engine states and small helpers used by the scanner and its bench.
package keypad_scan_pkg;

  localparam int KP_COLS = 4;
  localparam int KP_ROWS = 4;
  localparam int KP_KEYS = KP_COLS * KP_ROWS;
  localparam int KP_EV_W = 5;

  typedef enum logic {
    KP_IDLE = 1'b0,
    KP_EMIT = 1'b1
  } kp_state_t;

  // Active-low column drive with only the selected column pulled low.
  function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] ci);
    col_drive = ~(KP_COLS'(1) << ci);
  endfunction

  function automatic logic [KP_EV_W-1:0] make_event(input logic pressed,
                                                    input logic [3:0] idx);
    make_event = {pressed, idx};
  endfunction

endpackage

// File: rtl/keypad_scan_evfifo.sv
// Synchronous show-ahead FIFO holding keypad press/release events.
// The head entry is visible on q whenever valid is high; q reads zero when empty.
module kp_evfifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign q       = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, debounced key bitmap and a
// press/release event queue read by the host through ev_rd.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [KP_COLS-1:0]              col,
  input  logic [KP_ROWS-1:0]              row,
  output logic [KP_KEYS-1:0]              keys,
  output logic                            key_any,
  output logic                            ev_valid,
  output logic [KP_EV_W-1:0]              ev_data,
  input  logic                            ev_rd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DC_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [KP_ROWS-1:0] row_meta;
  logic [KP_ROWS-1:0] row_sync;
  logic [KP_ROWS-1:0] rs;
  logic [DIV_W-1:0]   div;
  logic [1:0]         ci;
  logic [KP_KEYS-1:0] raw;
  logic [KP_KEYS-1:0] raw_new;
  logic [KP_KEYS-1:0] cand;
  logic [KP_KEYS-1:0] cand_next;
  logic [KP_KEYS-1:0] diff;
  logic [DC_W-1:0]    dcnt;
  logic [DC_W-1:0]    dcnt_next;
  logic               div_tc;
  logic               scan_end;
  logic               update;

  kp_state_t          state;
  logic [3:0]         ei;
  logic               push_r;
  logic [KP_EV_W-1:0] push_data;
  logic               fifo_full;
  logic               drop;

  assign rs       = ~row_sync;
  assign div_tc   = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_end = div_tc && (ci == 2'd3);
  assign key_any  = |keys;

  // The full-scan image as it will look once the current column is captured.
  always_comb begin
    raw_new = raw;
    raw_new[{ci, 2'b00} +: KP_ROWS] = rs;
  end

  always_comb begin
    cand_next = cand;
    dcnt_next = dcnt;
    if (raw_new == cand) begin
      if (dcnt != DC_W'(DEBOUNCE_SCANS)) dcnt_next = dcnt + DC_W'(1);
    end else begin
      cand_next = raw_new;
      dcnt_next = DC_W'(1);
    end
  end

  assign update = scan_end && (dcnt_next == DC_W'(DEBOUNCE_SCANS)) && (cand_next != keys);

  // Rows are sampled on the last dwell cycle so the driven column has settled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= '1;
      row_sync <= '1;
      div      <= '0;
      ci       <= '0;
      col      <= col_drive(2'd0);
      raw      <= '0;
      cand     <= '0;
      dcnt     <= '0;
      keys     <= '0;
      diff     <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (div_tc) begin
        div <= '0;
        raw <= raw_new;
        ci  <= ci + 2'd1;
        col <= col_drive(ci + 2'd1);
      end else begin
        div <= div + DIV_W'(1);
      end
      if (scan_end) begin
        cand <= cand_next;
        dcnt <= dcnt_next;
      end
      if (update) begin
        diff <= keys ^ cand_next;
        keys <= cand_next;
      end
    end
  end

  // Event engine: one key index per cycle, pushing an event for each changed key.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= KP_IDLE;
      ei        <= '0;
      push_r    <= 1'b0;
      push_data <= '0;
    end else begin
      push_r <= 1'b0;
      case (state)
        KP_IDLE: begin
          if (update) begin
            state <= KP_EMIT;
            ei    <= '0;
          end
        end
        KP_EMIT: begin
          push_r    <= diff[ei];
          push_data <= make_event(keys[ei], ei);
          ei        <= ei + 4'd1;
          if (ei == 4'd15) state <= KP_IDLE;
        end
        default: state <= KP_IDLE;
      endcase
    end
  end

  assign drop = push_r && fifo_full && !ev_rd;

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  always_ff @(posedge clk) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  kp_evfifo #(
    .WIDTH(KP_EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_evfifo (
    .clk  (clk),
    .reset(reset),
    .push (push_r),
    .data (push_data),
    .pop  (ev_rd),
    .valid(ev_valid),
    .q    (ev_data),
    .count(ev_count),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model answers the column drive,
// expected events are queued at stimulus time and a monitor pops and compares them.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 20;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int FIFO_DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys;
  logic        key_any;
  logic        ev_valid;
  logic [4:0]  ev_data;
  logic        ev_rd;
  logic [2:0]  ev_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic        mon_rd = 1'b0;
  logic        stim_rd = 1'b0;
  logic        mon_en = 1'b0;
  logic [15:0] held = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [4:0]  exp_q [$];

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .col     (col),
    .row     (row),
    .keys    (keys),
    .key_any (key_any),
    .ev_valid(ev_valid),
    .ev_data (ev_data),
    .ev_rd   (ev_rd),
    .ev_count(ev_count),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  assign ev_rd = mon_rd | stim_rd;

  // Keypad model: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c]) row = row & ~held[c*4 +: 4];
  end

  // Edges since reset release: after edge n, cyc == n+1.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    held = k;
  endtask

  task automatic waitEdge(input int n);
    while (cyc < n + 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    held  = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_col"},      16'(col),      16'h000E);
    checkOutput({tag, "_keys"},     keys,          16'h0000);
    checkOutput({tag, "_key_any"},  16'(key_any),  16'h0000);
    checkOutput({tag, "_ev_valid"}, 16'(ev_valid), 16'h0000);
    checkOutput({tag, "_ev_data"},  16'(ev_data),  16'h0000);
    checkOutput({tag, "_ev_count"}, 16'(ev_count), 16'h0000);
    checkOutput({tag, "_overflow"}, 16'(overflow), 16'h0000);
  endtask

  // Monitor: pops whatever event the DUT presents and compares it with the queue.
  initial begin
    logic [4:0] exp;
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (mon_en && ev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got %b expected none at cyc %0d", ev_data, cyc);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("ev_data", 16'(ev_data), 16'(exp));
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_col;

    // Reset values, then the column rotation with a 20-cycle dwell.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      waitEdge(n);
      exp_col = 4'hF;
      exp_col[((n + 1) / 20) % 4] = 1'b0;
      checkOutput("col_rotation", 16'(col), 16'(exp_col));
    end
    checkOutput("t1_keys", keys, 16'h0000);
    checkOutput("t1_ev_valid", 16'(ev_valid), 16'h0000);

    // Hold idx 6 for three scans, then release it.
    doReset();
    exp_q.push_back(5'b1_0110);
    applyStimulus(16'h0040);
    waitEdge(200);
    checkOutput("t2_keys_pressed", keys, 16'h0040);
    checkOutput("t2_key_any", 16'(key_any), 16'h0001);
    exp_q.push_back(5'b0_0110);
    applyStimulus(16'h0000);
    waitEdge(440);
    checkOutput("t2_keys_released", keys, 16'h0000);
    checkOutput("t2_key_any_released", 16'(key_any), 16'h0000);
    checkOutput("t2_queue_drained", 16'(exp_q.size()), 16'h0000);

    // Idx 9 seen in a single scan only: no event, keys unchanged.
    doReset();
    waitEdge(40);
    applyStimulus(16'h0200);
    waitEdge(120);
    applyStimulus(16'h0000);
    waitEdge(300);
    checkOutput("t3_keys", keys, 16'h0000);
    checkOutput("t3_ev_count", 16'(ev_count), 16'h0000);

    // Two keys in the same scan come out in ascending index order.
    doReset();
    exp_q.push_back(5'b1_0001);
    exp_q.push_back(5'b1_1110);
    applyStimulus(16'h4002);
    waitEdge(200);
    checkOutput("t4_keys", keys, 16'h4002);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_1110);
    applyStimulus(16'h0000);
    waitEdge(440);
    checkOutput("t4_keys_released", keys, 16'h0000);
    checkOutput("t4_queue_drained", 16'(exp_q.size()), 16'h0000);

    // Five events into a four-deep FIFO with no reads.
    mon_en = 1'b0;
    doReset();
    applyStimulus(16'h001F);
    waitEdge(170);
    checkOutput("t5_ev_count_full", 16'(ev_count), 16'h0004);
    checkOutput("t5_overflow_set", 16'(overflow), 16'h0001);
    checkOutput("t5_head", 16'(ev_data), 16'(5'b1_0000));
    checkOutput("t5_keys", keys, 16'h001F);
    // Releasing idx 0 yields one push at edge 321; pop in that same cycle.
    applyStimulus(16'h001E);
    waitEdge(320);
    checkOutput("t5_count_before_pushpop", 16'(ev_count), 16'h0004);
    stim_rd = 1'b1;
    waitEdge(321);
    stim_rd = 1'b0;
    checkOutput("t5_count_pushpop", 16'(ev_count), 16'h0004);
    checkOutput("t5_head_after_pop", 16'(ev_data), 16'(5'b1_0001));
    checkOutput("t5_overflow_sticky", 16'(overflow), 16'h0001);
    waitEdge(330);
    ovf_clr = 1'b1;
    waitEdge(331);
    ovf_clr = 1'b0;
    checkOutput("t5_overflow_cleared", 16'(overflow), 16'h0000);
    exp_q.push_back(5'b1_0001);
    exp_q.push_back(5'b1_0010);
    exp_q.push_back(5'b1_0011);
    exp_q.push_back(5'b0_0000);
    mon_en = 1'b1;
    waitEdge(345);
    checkOutput("t5_queue_drained", 16'(exp_q.size()), 16'h0000);
    checkOutput("t5_ev_count_empty", 16'(ev_count), 16'h0000);

    // Reset five cycles into EMIT, with one event already queued.
    mon_en = 1'b0;
    doReset();
    applyStimulus(16'h1008);
    waitEdge(164);
    checkOutput("t6_one_event_before_reset", 16'(ev_count), 16'h0001);
    applyStimulus(16'h0000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("t6_reset");
    reset = 1'b1;
    waitEdge(400);
    checkOutput("t6_ev_count_after", 16'(ev_count), 16'h0000);
    checkOutput("t6_ev_valid_after", 16'(ev_valid), 16'h0000);
    checkOutput("t6_keys_after", keys, 16'h0000);
    checkOutput("t6_overflow_after", 16'(overflow), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
